// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined carry adder: pipeline depth helper and
// the record carried by every pipeline stage.
package adder_pkg;

  // Widest operand the stage record can carry.
  localparam int MAX_WIDTH = 64;

  // Number of pipeline stages (and latency) for a given width and segment size.
  function automatic int calc_stages(input int width, input int seg);
    return (width + seg - 1) / seg;
  endfunction

  // One pipeline stage register: resolved sum bits so far, carry into the next
  // segment, carry into the top bit of the segment just resolved (used for
  // signed overflow in the last stage), and the pending propagate/generate bits
  // that later stages still have to consume.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic                 carry_msb;
    logic [MAX_WIDTH-1:0] sum;
    logic [MAX_WIDTH-1:0] p;
    logic [MAX_WIDTH-1:0] g;
  } stage_t;

endpackage

// File: rtl/adder_seg.sv
// One combinational N-bit propagate/generate ripple segment. The linear carry
// recurrence maps directly onto dedicated carry-chain cells.
module adder_seg #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_p,
  input  logic [N-1:0] i_g,
  input  logic         i_c,
  output logic [N-1:0] o_s,
  output logic         o_c,
  output logic         o_c_msb
);

  // Ripple the carry through the segment bit by bit.
  always_comb begin
    logic c;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    o_s     = '0;
    o_c_msb = 1'b0;
    c       = i_c;
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) o_c_msb = c;
      o_s[i] = i_p[i] ^ c;
      c      = i_g[i] | (i_p[i] & c);
    end
    o_c = c;
  end

endmodule

// File: rtl/pipelined_carry_adder.sv
// Pipelined ripple-carry adder/subtractor. Each stage resolves SEG bits of the
// carry chain; the whole pipeline advances together under valid/ready control.
module pipelined_carry_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = calc_stages(WIDTH, SEG);

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  stage_t           w_head;
  stage_t           w_next  [STAGES];
  stage_t           r_stage [STAGES];

  // The whole pipeline moves only when the output slot is free or being taken.
  assign w_adv    = !r_stage[STAGES-1].valid || out_ready;
  assign in_ready = w_adv;
  assign w_b_eff  = sub ? ~b : b;

  // Build the record entering stage 0; a cleared valid bit injects a bubble.
  always_comb begin
    w_head                = '0;
    w_head.valid          = in_valid;
    w_head.carry          = cin;
    w_head.p[WIDTH-1:0]   = a ^ w_b_eff;
    w_head.g[WIDTH-1:0]   = a & w_b_eff;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int N  = (WIDTH - LO < SEG) ? (WIDTH - LO) : SEG;

    stage_t         w_in;
    stage_t         w_out;
    logic [N-1:0]   w_s;
    logic           w_co;
    logic           w_cmsb;

    if (k == 0) begin : g_first
      assign w_in = w_head;
    end else begin : g_rest
      assign w_in = r_stage[k-1];
    end

    adder_seg #(.N(N)) u_seg (
      .i_p     (w_in.p[LO +: N]),
      .i_g     (w_in.g[LO +: N]),
      .i_c     (w_in.carry),
      .o_s     (w_s),
      .o_c     (w_co),
      .o_c_msb (w_cmsb)
    );

    // Merge this segment's result into the record passed to the next register.
    always_comb begin
      w_out               = w_in;
      w_out.sum[LO +: N]  = w_s;
      w_out.carry         = w_co;
      w_out.carry_msb     = w_cmsb;
    end

    assign w_next[k] = w_out;
  end

  // Stage registers: reset clears in-flight work and outputs, stall holds all.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge values.
    if (rst) begin
      for (int k = 0; k < STAGES; k++) r_stage[k] <= '0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) r_stage[k] <= w_next[k];
    end
  end

  assign out_valid = r_stage[STAGES-1].valid;
  assign sum       = r_stage[STAGES-1].sum[WIDTH-1:0];
  assign cout      = r_stage[STAGES-1].carry;
  assign ovf       = r_stage[STAGES-1].carry ^ r_stage[STAGES-1].carry_msb;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Self-checking bench: table-driven vectors and scoreboards for a 16/4 adder,
// plus random streams into 10/4 and 8/8 instances checked against a model.
module tb_pipelined_carry_adder;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [17:0] exp;   // {ovf, cout, sum}
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit, 4-bit segment instance
  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  // Shared random stimulus for the two extra instances
  logic        rst_x, x_iv, x_cin, x_sub, x_or;
  logic [15:0] x_a, x_b;
  logic        x10_in_ready, x10_out_valid, x10_cout, x10_ovf;
  logic [9:0]  x10_sum;
  logic        x8_in_ready, x8_out_valid, x8_cout, x8_ovf;
  logic [7:0]  x8_sum;

  int n_checks = 0;
  int n_errors = 0;

  logic [17:0] q_main [$];
  logic [17:0] q10 [$];
  logic [17:0] q8 [$];

  logic        prev_stall = 1'b0;
  logic [17:0] held;
  vec_t        vecs [10];

  pipelined_carry_adder #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_carry_adder #(.WIDTH(10), .SEG(4)) dut10 (
    .clk(clk), .rst(rst_x), .in_valid(x_iv), .in_ready(x10_in_ready),
    .a(x_a[9:0]), .b(x_b[9:0]), .cin(x_cin), .sub(x_sub),
    .out_valid(x10_out_valid), .out_ready(x_or),
    .sum(x10_sum), .cout(x10_cout), .ovf(x10_ovf)
  );

  pipelined_carry_adder #(.WIDTH(8), .SEG(8)) dut8 (
    .clk(clk), .rst(rst_x), .in_valid(x_iv), .in_ready(x8_in_ready),
    .a(x_a[7:0]), .b(x_b[7:0]), .cin(x_cin), .sub(x_sub),
    .out_valid(x8_out_valid), .out_ready(x_or),
    .sum(x8_sum), .cout(x8_cout), .ovf(x8_ovf)
  );

  // Arithmetic reference: plain integer addition, overflow from operand/result signs.
  function automatic logic [17:0] ref_add(input int w, input logic [15:0] fa, input logic [15:0] fb,
                                          input logic fcin, input logic fsub);
    longint unsigned m, av, bx, full, s;
    logic co, ov;
    m    = (64'd1 << w) - 64'd1;
    av   = {48'd0, fa} & m;
    bx   = fsub ? (~{48'd0, fb}) & m : {48'd0, fb} & m;
    full = av + bx + {63'd0, fcin};
    s    = full & m;
    co   = full[w];
    ov   = (av[w-1] == bx[w-1]) && (s[w-1] != av[w-1]);
    return {ov, co, s[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one operation and hold it until accepted; returns just after the acceptance edge.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tcin, input logic tsub,
                      input logic [17:0] texp);
    bit ok = 0;
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        q_main.push_back(texp);
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout: in_ready never high for a=%h b=%h", ta, tb);
    end
  endtask

  task automatic send_random();
    logic [31:0] r1, r2;
    r1 = $urandom;
    r2 = $urandom;
    send(r1[15:0], r1[31:16], r2[0], r2[1], ref_add(16, r1[15:0], r1[31:16], r2[0], r2[1]));
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100; i++) begin
      if (q_main.size() == 0) break;
      @(posedge clk); #1;
    end
    check(name, q_main.size(), 0);
  endtask

  // Count edges from acceptance until the result shows up on the output.
  task automatic measure_latency(input vec_t v, input string name);
    int  n;
    bit  seen = 0;
    send(v.a, v.b, v.cin, v.sub, v.exp);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    if (!seen) n = -1;
    check(name, n, 4);
  endtask

  // Scoreboard monitor, sampled on the falling edge where all signals are settled.
  always @(negedge clk) begin
    logic [17:0] e;
    if (out_valid === 1'b1 && out_ready) begin
      if (q_main.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL main_extra: unexpected result %h", {ovf, cout, sum});
      end else begin
        e = q_main.pop_front();
        check("main_result", {ovf, cout, sum}, e);
      end
    end
    if (out_valid === 1'b1 && !out_ready) begin
      check("stall_in_ready", in_ready, 0);
      if (prev_stall) check("stall_stable", {ovf, cout, sum}, held);
      held       = {ovf, cout, sum};
      prev_stall = 1'b1;
    end else begin
      prev_stall = 1'b0;
    end

    if (rst_x === 1'b0) begin
      if (x10_out_valid && x_or) begin
        if (q10.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL dut10_extra: unexpected result %h", x10_sum);
        end else begin
          e = q10.pop_front();
          check("dut10_result", {x10_ovf, x10_cout, 6'd0, x10_sum}, e);
        end
      end
      if (x8_out_valid && x_or) begin
        if (q8.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL dut8_extra: unexpected result %h", x8_sum);
        end else begin
          e = q8.pop_front();
          check("dut8_result", {x8_ovf, x8_cout, 8'd0, x8_sum}, e);
        end
      end
      if (x_iv && x10_in_ready) q10.push_back(ref_add(10, x_a, x_b, x_cin, x_sub));
      if (x_iv && x8_in_ready)  q8.push_back(ref_add(8, x_a, x_b, x_cin, x_sub));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t0;
    logic [31:0] r;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 18'h00100};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 18'h0FFFE};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 18'h37FFF};
    vecs[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 18'h05556};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 18'h10000};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 18'h1FFFF};
    vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 18'h30000};
    vecs[9] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 18'h01000};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    rst_x = 1'b1; x_iv = 1'b0; x_a = '0; x_b = '0; x_cin = 1'b0; x_sub = 1'b0; x_or = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", sum, 0);
    check("reset_cout", cout, 0);
    check("reset_ovf", ovf, 0);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Single operation latency
    measure_latency(vecs[0], "latency_first");
    drain("drain_first");

    // Table streamed back to back: one acceptance per cycle
    t0 = $time;
    for (int i = 0; i < 10; i++) send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].exp);
    check("throughput_cycles", 32'(($time - t0) / 10), 10);
    drain("drain_table");

    // Eight operations with a three-cycle output stall mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++) send_random();
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("drain_stall");

    // Reset with three operations in flight and a fourth offered during reset
    for (int i = 0; i < 3; i++) send_random();
    rst = 1'b1;
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
    q_main.delete();
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1);
    check("flush_out_valid", out_valid, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("flush_quiet", out_valid, 0);
    end
    @(posedge clk); #1;
    measure_latency(vecs[9], "latency_after_reset");
    drain("drain_after_reset");

    // Random streams into the 10/4 and 8/8 instances
    @(posedge clk); #1 rst_x = 1'b0;
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      x_a = r[15:0];
      x_b = r[31:16];
      r = $urandom;
      x_cin = r[0];
      x_sub = r[1];
      x_iv  = (r[4:2] != 3'd0);
      x_or  = (r[7:5] != 3'd0);
      if (r[11:8] == 4'd0)  x_a = 16'hFFFF;
      if (r[15:12] == 4'd0) x_b = 16'h0001;
      @(posedge clk); #1;
    end
    x_iv = 1'b0; x_or = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("drain_dut10", q10.size(), 0);
    check("drain_dut8", q8.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipelined_carry_adder.md
PIPELINED_CARRY_ADDER -- requirements
Module: pipelined_carry_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits, minimum 1.
REQ-002 SHALL have parameter SEG, default 4: carry-chain bits resolved per pipeline stage, range 1..WIDTH.
REQ-003 SHALL define derived constant STAGES = ceil(WIDTH/SEG), the pipeline depth and latency in cycles.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1: operands present.
REQ-007 SHALL have port in_ready, output, 1: block accepts operands this cycle.
REQ-008 SHALL have port a, input, WIDTH: operand A.
REQ-009 SHALL have port b, input, WIDTH: operand B.
REQ-010 SHALL have port cin, input, 1: carry into bit 0.
REQ-011 SHALL have port sub, input, 1: 0 selects a+b+cin, 1 selects a+~b+cin.
REQ-012 SHALL have port out_valid, output, 1: result present.
REQ-013 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-014 SHALL have port sum, output, WIDTH: result.
REQ-015 SHALL have port cout, output, 1: carry out of bit WIDTH-1.
REQ-016 SHALL have port ovf, output, 1: two's-complement signed overflow.

Function
REQ-017 SHALL form per-bit propagate p = a ^ b' and generate g = a & b', where b' = sub ? ~b : b.
REQ-018 SHALL ripple carry as c(i+1) = g(i) | (p(i) & c(i)) and compute sum(i) = p(i) ^ c(i).
REQ-019 Stage k SHALL resolve bits [k*SEG, min((k+1)*SEG, WIDTH)-1]; the last stage SHALL be narrower when WIDTH is not a multiple of SEG.
REQ-020 Stage k SHALL register its resolved sum bits, its carry out, a valid bit, and the unresolved p/g bits for later stages.
REQ-021 The registered carry out of stage k SHALL be the carry in of stage k+1 on the following cycle.
REQ-022 Resolved sum bits SHALL be delayed so all bits of a result leave together.
REQ-023 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when there is no stall; SEG == WIDTH gives latency 1.
REQ-024 Acceptance SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-025 Pipeline advance enable SHALL be adv = !out_valid || out_ready.
REQ-026 in_ready SHALL equal adv.
REQ-027 When adv = 0, all stage registers SHALL hold.
REQ-028 When adv = 1 with no acceptance, a bubble (valid = 0) SHALL enter stage 0.
REQ-029 Full pipeline with out_ready = 1 and in_valid = 1 SHALL accept and retire in the same cycle, sustaining 1 result/cycle.
REQ-030 sum, cout and ovf SHALL remain stable while out_valid && !out_ready.
REQ-031 cout SHALL be the carry out of bit WIDTH-1 with no sub inversion; on subtract, cout = 1 means no borrow.
REQ-032 ovf SHALL equal c(WIDTH) ^ c(WIDTH-1).
REQ-033 Wrap-around SHALL be modulo 2^WIDTH, e.g. all-ones + 1 gives sum 0 and cout 1.

Reset
REQ-034 On clk edge with rst = 1, all stage valid bits SHALL clear: out_valid = 0, sum = 0, cout = 0, ovf = 0.
REQ-035 in_ready SHALL be 1 in the cycle following reset.
REQ-036 rst during operation SHALL discard all in-flight operations; none SHALL ever appear at the output.
REQ-037 rst SHALL take priority over acceptance in the same cycle.

Structure
REQ-038 Package adder_pkg SHALL hold the STAGES computation function and the per-stage register record typedef (sum slice, carry, valid, pending p/g).
REQ-039 Sub-module adder_seg (parameter N) SHALL implement one combinational N-bit p/g ripple segment, instantiated once per stage, mappable onto CARRY_CHAIN cells.

Verification (WIDTH=16, SEG=4 unless stated)
REQ-040 Reset, then a=0x00FF, b=0x0001, cin=0, sub=0 at cycle 0 -> out_valid at cycle 4, sum=0x0100, cout=0, ovf=0.
REQ-041 a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1; a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1.
REQ-042 sub=1, cin=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; a=0x8000, b=0x0001 -> ovf=1.
REQ-043 Stream 8 back-to-back operations with out_ready held at 0 for 3 cycles mid-stream -> all 8 results in order, none dropped or duplicated, outputs stable while stalled.
REQ-044 Assert rst with 3 operations in flight -> out_valid = 0 next cycle, none of the 3 emerge; the next accepted operation arrives after 4 cycles.
REQ-045 WIDTH=10, SEG=4 (3 stages), and WIDTH=SEG=8 (latency 1), with random operands -> results match a reference model.
